// File: rtl/blowfish128_skey_ctrl.sv
`timescale 1ns/1ps
// Blowfish-style 128-bit subkey expansion controller: XORs the key stream into a
// 20-entry P-array, then chains 5 engine calls to overwrite it. Option: BF128_SKEY_REVERSE_EN.
module blowfish128_skey_ctrl (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [3:0]   key_length,
  output logic [2:0]   key_idx,
  input  logic [63:0]  key_word,
  output logic         enc_start,
  output logic [127:0] enc_blk_in,
  input  logic         enc_done,
  input  logic [127:0] enc_blk_out,
  input  logic [4:0]   p_rd_idx,
  output logic [31:0]  p_rd_data,
  output logic         busy,
  output logic         skey_ready
`ifdef BF128_SKEY_REVERSE_EN
  ,
  input  logic         p_rev
`endif
);

  localparam logic [31:0] P_INIT [20] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
    32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
  };

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_XOR, S_REQ, S_WAIT, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [31:0]    p_q [20];
  logic [31:0]    p_d [20];
  logic [127:0]   b_q, b_d;
  logic [2:0]     r_q, r_d;
  logic [4:0]     j_q, j_d;
  logic [3:0]     kpos_q, kpos_d;
  logic [3:0]     lk_q, lk_d;
  logic           busy_q, busy_d;
  logic           skey_ready_q, skey_ready_d;

  logic [3:0]     lk_eff;
  logic           kpos_last;
  logic [31:0]    key_half;
  logic [4:0]     wr_base;
  logic [4:0]     rd_idx;

  assign lk_eff    = (key_length == 4'd0) ? 4'd1 :
                     (key_length > 4'd8)  ? 4'd8 : key_length;
  // kpos tracks j mod 2*Lk incrementally, so no divider is needed.
  assign kpos_last = ({1'b0, kpos_q} == ({lk_q, 1'b0} - 5'd1));
  assign key_half  = kpos_q[0] ? key_word[31:0] : key_word[63:32];
  assign wr_base   = {r_q, 2'b00};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (Start) state_d = S_LOAD;
      S_LOAD:         state_d = S_XOR;
      S_XOR:          if (j_q == 5'd19) state_d = S_REQ;
      S_REQ:          state_d = S_WAIT;
      S_WAIT:         if (enc_done) state_d = (r_q == 3'd4) ? S_DONE : S_REQ;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    enc_start = (state_q == S_REQ);
    key_idx   = (state_q == S_XOR) ? kpos_q[3:1] : 3'd0;
  end

  always_comb begin
    p_d          = p_q;
    b_d          = b_q;
    r_d          = r_q;
    j_d          = j_q;
    kpos_d       = kpos_q;
    lk_d         = lk_q;
    busy_d       = busy_q;
    skey_ready_d = skey_ready_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          busy_d       = 1'b1;
          skey_ready_d = 1'b0;
        end else if (state_q == S_DONE) begin
          // Status settles one edge after DONE is entered.
          busy_d       = 1'b0;
          skey_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        p_d    = P_INIT;
        b_d    = '0;
        r_d    = 3'd0;
        j_d    = 5'd0;
        kpos_d = 4'd0;
        lk_d   = lk_eff;
      end
      S_XOR: begin
        p_d[j_q] = p_q[j_q] ^ key_half;
        j_d      = j_q + 5'd1;
        kpos_d   = kpos_last ? 4'd0 : kpos_q + 4'd1;
      end
      S_WAIT: begin
        if (enc_done) begin
          b_d = enc_blk_out;
          for (int k = 0; k < 4; k++) begin
            p_d[wr_base + 5'(k)] = enc_blk_out[127 - 32*k -: 32];
          end
          r_d = r_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      // NOTE: the P-array resets to constants, so it must stay in flops rather than a RAM macro.
      p_q          <= P_INIT;
      b_q          <= '0;
      r_q          <= 3'd0;
      j_q          <= 5'd0;
      kpos_q       <= 4'd0;
      lk_q         <= 4'd1;
      busy_q       <= 1'b0;
      skey_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      p_q          <= p_d;
      b_q          <= b_d;
      r_q          <= r_d;
      j_q          <= j_d;
      kpos_q       <= kpos_d;
      lk_q         <= lk_d;
      busy_q       <= busy_d;
      skey_ready_q <= skey_ready_d;
    end
  end

  assign enc_blk_in = b_q;
  assign busy       = busy_q;
  assign skey_ready = skey_ready_q;

  always_comb begin
`ifdef BF128_SKEY_REVERSE_EN
    rd_idx = p_rev ? (5'd19 - p_rd_idx) : p_rd_idx;
`else
    rd_idx = p_rd_idx;
`endif
    p_rd_data = (p_rd_idx < 5'd20) ? p_q[rd_idx] : 32'd0;
  end

endmodule

// File: tb/tb_blowfish128_skey_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for blowfish128_skey_ctrl: directed steps plus randomized key runs
// compared against an arithmetic model of the key schedule and a +1 engine stub.
module tb_blowfish128_skey_ctrl;

  localparam logic [31:0] P_REF [20] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
    32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
  };

  logic         Clk = 1'b0;
  logic         Rst, Start;
  logic [3:0]   key_length;
  logic [2:0]   key_idx;
  logic [63:0]  key_word;
  logic         enc_start;
  logic [127:0] enc_blk_in;
  logic         enc_done;
  logic [127:0] enc_blk_out;
  logic [4:0]   p_rd_idx;
  logic [31:0]  p_rd_data;
  logic         busy, skey_ready;
`ifdef BF128_SKEY_REVERSE_EN
  logic         p_rev = 1'b0;
`endif

  logic [63:0]  key_mem [8];
  assign key_word = key_mem[key_idx];

  blowfish128_skey_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .key_length(key_length),
    .key_idx(key_idx), .key_word(key_word), .enc_start(enc_start),
    .enc_blk_in(enc_blk_in), .enc_done(enc_done), .enc_blk_out(enc_blk_out),
    .p_rd_idx(p_rd_idx), .p_rd_data(p_rd_data), .busy(busy), .skey_ready(skey_ready)
`ifdef BF128_SKEY_REVERSE_EN
    , .p_rev(p_rev)
`endif
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          stub_en  = 1'b0;
  int          stub_d   = 1;
  int          stub_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] exp_p [20];
  int          q_edge [$];
  logic [127:0] q_blk [$];

  // Engine stub: answers blk_in+1 exactly stub_d cycles after the enc_start cycle.
  initial begin
    enc_done    = 1'b0;
    enc_blk_out = '0;
    forever begin
      @(negedge Clk);
      enc_done = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          enc_done    = 1'b1;
          enc_blk_out = enc_blk_in + 128'd1;
          done_cnt++;
        end
      end
      if (enc_start && stub_en) stub_cnt = stub_d;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input logic [3:0] kl);
    if (kl == 4'd0) return 1;
    if (kl > 4'd8)  return 8;
    return int'(kl);
  endfunction

  // P after the key XOR pass: P_INIT[j] ^ 32-bit word (j mod 2*lk) of the key stream.
  task automatic model_xor(input int lk);
    for (int j = 0; j < 20; j++) begin
      int pos = j % (2*lk);
      logic [63:0] w = key_mem[pos/2];
      exp_p[j] = P_REF[j] ^ ((pos % 2 == 1) ? w[31:0] : w[63:32]);
    end
  endtask

  // With a +1 engine starting from B=0, round r returns r+1 and fills P[4r..4r+3].
  task automatic model_rounds();
    logic [127:0] b = '0;
    for (int r = 0; r < 5; r++) begin
      b = b + 128'd1;
      for (int k = 0; k < 4; k++) exp_p[4*r + k] = b[127 - 32*k -: 32];
    end
  endtask

  task automatic read_p(input int i, output logic [31:0] v);
    p_rd_idx = 5'(i);
    #1;
    v = p_rd_data;
  endtask

  task automatic check_all_p(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 20; i++) begin
      read_p(i, v);
      check($sformatf("%s[%0d]", tag, i), v, exp_p[i]);
    end
  endtask

  task automatic random_keys();
    for (int i = 0; i < 8; i++) key_mem[i] = {$urandom, $urandom};
  endtask

  // Full expansion; edge 0 is the edge that samples Start. Optionally pokes Start mid-XOR.
  task automatic run_full(input int d, input bit poke);
    int ready_edge = -1;
    bit idx_ok     = 1'b1;
    int lk         = eff_len(key_length);
    logic [127:0] eb = '0;
    q_edge.delete();
    q_blk.delete();
    stub_d  = d;
    stub_en = 1'b1;
    @(negedge Clk); Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    check("busy_at_start", busy, 1);
    check("ready_clear_at_start", skey_ready, 0);
    for (int k = 1; k <= 300; k++) begin
      @(posedge Clk); #1;
      if (poke) Start = (k == 10);
      if (k <= 20 && key_idx !== 3'(((k-1) % (2*lk)) / 2)) idx_ok = 1'b0;
      if (enc_start) begin
        q_edge.push_back(k);
        q_blk.push_back(enc_blk_in);
      end
      if (skey_ready) begin
        ready_edge = k;
        break;
      end
    end
    Start = 1'b0;
    check("key_idx_during_xor", idx_ok, 1);
    check("ready_latency", 128'(ready_edge), 128'(22 + 5*(d+1)));
    check("busy_at_ready", busy, 0);
    check("enc_start_count", 128'(q_edge.size()), 128'd5);
    for (int r = 0; r < 5 && r < q_edge.size(); r++) begin
      check($sformatf("enc_start_edge_r%0d", r), 128'(q_edge[r]), 128'(21 + r*(d+1)));
      check($sformatf("enc_blk_in_r%0d", r), q_blk[r], eb);
      eb = eb + 128'd1;
    end
    model_xor(lk);
    model_rounds();
    check_all_p("p_final");
  endtask

  initial begin
    logic [31:0] v;
    int cnt;
    int done_before;
    bit seen;

    Rst = 1'b1; Start = 1'b0; key_length = 4'd1; p_rd_idx = 5'd0;
    for (int i = 0; i < 8; i++) key_mem[i] = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    // Reset state
    read_p(0, v);  check("init_p0", v, 32'h243F6A88);
    read_p(17, v); check("init_p17", v, 32'h8979FB1B);
    read_p(19, v); check("init_p19", v, 32'h98DFB5AC);
    read_p(25, v); check("rd_out_of_range", v, 32'd0);
    check("rst_busy", busy, 0);
    check("rst_skey_ready", skey_ready, 0);
    check("rst_enc_start", enc_start, 0);
    check("rst_key_idx", key_idx, 0);
    check("rst_enc_blk_in", enc_blk_in, 0);

    // Lk=1 directed run, D=3, with an ignored Start during XOR
    key_length = 4'd1;
    key_mem[0] = 64'h0123456789ABCDEF;
    run_full(3, 1'b1);
`ifdef BF128_SKEY_REVERSE_EN
    p_rev = 1'b1;
    read_p(0, v);  check("rev_idx0", v, exp_p[19]);
    read_p(19, v); check("rev_idx19", v, exp_p[0]);
    p_rev = 1'b0;
`endif

    // DONE holds: ready stays, P frozen while key inputs change
    key_mem[0] = {$urandom, $urandom};
    key_length = 4'd7;
    repeat (6) @(posedge Clk);
    #1;
    check("done_ready_held", skey_ready, 1);
    check("done_busy_low", busy, 0);
    check_all_p("p_frozen");

    // Restart from DONE with Lk=4, engine stalled; key_length changed after LOAD
    random_keys();
    key_length = 4'd4;
    stub_en    = 1'b0;
    @(negedge Clk); Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    @(posedge Clk); #1; key_length = 4'd2;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (enc_start) begin seen = 1'b1; break; end
    end
    check("stall_enc_start_seen", seen, 1);
    check("stall_blk_in_zero", enc_blk_in, 0);
    model_xor(4);
    read_p(0, v); check("xor_p0", v, 32'h243F6A88 ^ key_mem[0][63:32]);
    read_p(7, v); check("xor_p7", v, 32'hEC4E6C89 ^ key_mem[3][31:0]);
    check_all_p("p_xor");
    repeat (4) @(posedge Clk);
    #1;
    check("stall_busy", busy, 1);
    check("stall_enc_start_once", enc_start, 0);
    check("stall_not_ready", skey_ready, 0);
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk); Rst = 1'b0;

    // Randomized runs
    for (int it = 0; it < 3; it++) begin
      random_keys();
      key_length = 4'($urandom_range(0, 15));
      run_full($urandom_range(1, 4), 1'b0);
    end

    // Reset during round 3, then a late enc_done after release
    key_length = 4'd2;
    random_keys();
    stub_d  = 3;
    stub_en = 1'b1;
    @(negedge Clk); Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge Clk); #1;
      if (enc_start) cnt++;
      if (cnt == 4) break;
    end
    check("reached_round3", 128'(cnt), 128'd4);
    done_before = done_cnt;
    @(negedge Clk); #1; Rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_skey_ready", skey_ready, 0);
    check("midrst_enc_start", enc_start, 0);
    check("midrst_key_idx", key_idx, 0);
    check("midrst_enc_blk_in", enc_blk_in, 0);
    for (int i = 0; i < 20; i++) exp_p[i] = P_REF[i];
    check_all_p("p_midrst");
    Rst = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    check("late_done_delivered", 128'(done_cnt - done_before), 128'd1);
    check("late_busy", busy, 0);
    check("late_skey_ready", skey_ready, 0);
    check_all_p("p_late_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
